// File: rtl/ahb_lite_ram_slave.sv
// AHB-Lite RAM slave: programmable wait states, byte-lane writes,
// two-cycle ERROR response for out-of-range or misaligned transfers.
`timescale 1ns/1ps
module ahb_lite_ram_slave #(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HBURST,
  input  logic        HSEL,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [3:0] WS_INIT =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    off_q, off_d;
  logic [1:0]    size_q, size_d;
  logic          write_q, write_d;
  logic          rdy_q, resp_q;
  logic [31:0]   mem [MEM_WORDS];

  logic       can_take, accept, bad;
  logic [3:0] be;
  logic       unused_bits;

  assign unused_bits = ^{HBURST, HTRANS[0]};

  assign can_take = state_q inside {S_IDLE, S_LAST, S_ERR2};
  assign accept   = can_take && HSEL && HREADY && HTRANS[1];

  assign bad = ({2'b0, HADDR[31:2]} >= 32'(MEM_WORDS))
            || (HSIZE > 3'd2)
            || (HSIZE == 3'd1 && HADDR[0])
            || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    off_d   = off_q;
    size_d  = size_q;
    write_d = write_q;
    unique case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_LAST;
        else cnt_d = cnt_q - 4'd1;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    // a pipelined address phase overrides the return to IDLE
    if (accept) begin
      idx_d   = HADDR[AW+1:2];
      off_d   = HADDR[1:0];
      size_d  = HSIZE[1:0];
      write_d = HWRITE;
      if (bad) begin
        state_d = S_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_d = S_WAIT;
        cnt_d   = WS_INIT;
      end else begin
        state_d = S_LAST;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      off_q   <= 2'b00;
      size_q  <= 2'b00;
      write_q <= 1'b0;
      rdy_q   <= 1'b1;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      size_q  <= size_d;
      write_q <= write_d;
      rdy_q   <= !(state_d == S_WAIT || state_d == S_ERR1);
      resp_q  <= (state_d == S_ERR1 || state_d == S_ERR2);
    end
  end

  always_comb begin
    be = 4'b0000;
    unique case (size_q)
      2'd0:    be = 4'b0001 << off_q;
      2'd1:    be = off_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // reset drops state_q to IDLE at once, so an aborted write never lands
  always_ff @(posedge HCLK) begin
    if (state_q == S_LAST && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HRDATA    = (state_q == S_LAST && !write_q) ? mem[idx_q] : 32'h0;
  assign HREADYOUT = rdy_q;
  assign HRESP     = resp_q;

endmodule

// File: tb/tb_ahb_lite_ram_slave.sv
// Bench: two slaves (WAIT_STATES 0 and 1) checked every cycle against a
// transfer-timeline model; directed scenarios plus randomized traffic.
`timescale 1ns/1ps
module tb_ahb_lite_ram_slave;
  typedef struct {
    bit rdy; bit resp; bit rd; bit wr;
    int idx; int off; int nb;
  } cyc_t;

  typedef struct {
    bit sel; logic [1:0] tr; bit wr;
    logic [2:0] sz; logic [31:0] a; logic [31:0] d;
  } op_t;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b0;
  logic [31:0] HADDR = '0;
  logic [31:0] HWDATA = '0;
  logic [2:0]  HBURST = '0;
  logic [2:0]  HSIZE = '0;
  logic [1:0]  HTRANS = '0;
  logic        HWRITE = 1'b0;
  logic [1:0]  hsel = '0;
  logic        hrdy [2];
  logic        hrsp [2];
  logic [31:0] hrdata [2];

  int checks = 0;
  int fails = 0;
  bit chk_en = 0;

  op_t ops[$];
  int st [64];
  bit rsp0 [64];
  bit rsp [64];
  logic [31:0] rdv [64];

  always #5 HCLK = ~HCLK;

  task automatic chk(input string nm, input int d, input logic [31:0] got,
                     input logic [31:0] exp, input logic [31:0] m);
    checks++;
    if ((got & m) !== (exp & m)) begin
      fails++;
      $display("FAIL %s dut%0d t=%0t got=%h want=%h mask=%h",
               nm, d, $time, got, exp, m);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : G
    localparam int WS = (g == 0) ? 0 : 1;
    cyc_t q[$];
    logic [7:0] mb [4096];
    bit kv [4096];

    ahb_lite_ram_slave #(.MEM_WORDS(1024), .WAIT_STATES(WS)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HBURST(HBURST),
      .HSEL(hsel[g]), .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA),
      .HWRITE(HWRITE), .HREADY(hrdy[g]), .HRDATA(hrdata[g]),
      .HREADYOUT(hrdy[g]), .HRESP(hrsp[g]));

    // each accepted transfer becomes a list of expected output cycles
    always @(posedge HCLK or posedge HRESET) begin : mdl
      bit r, bad;
      cyc_t c;
      logic [11:0] bi;
      if (HRESET) begin
        q.delete();
      end else begin
        r = (q.size() == 0) ? 1'b1 : q[0].rdy;
        if (q.size() != 0) begin
          c = q.pop_front();
          if (c.wr) begin
            for (int b = 0; b < c.nb; b++) begin
              bi = 12'(c.idx * 4 + c.off + b);
              mb[bi] = HWDATA[8*(c.off+b) +: 8];
              kv[bi] = 1'b1;
            end
          end
        end
        if (r && hsel[g] && HTRANS[1]) begin
          bad = (HADDR >= 32'h1000) || (HSIZE > 3'd2)
             || ((HADDR & ((32'd1 << HSIZE) - 32'd1)) != 32'd0);
          c = '{default: 0};
          if (bad) begin
            c.resp = 1'b1;
            q.push_back(c);
            c.rdy = 1'b1;
            q.push_back(c);
          end else begin
            repeat (WS) q.push_back(c);
            c.rdy = 1'b1;
            c.idx = int'(HADDR[11:2]);
            c.off = int'(HADDR[1:0]);
            c.nb  = 32'd1 << HSIZE;
            c.wr  = HWRITE;
            c.rd  = !HWRITE;
            q.push_back(c);
          end
        end
      end
    end

    always @(negedge HCLK) begin : cmp
      logic [31:0] ew, m;
      logic [11:0] bi;
      bit er, es;
      if (chk_en) begin
        er = 1'b1; es = 1'b0; ew = '0; m = '1;
        if (q.size() != 0) begin
          er = q[0].rdy;
          es = q[0].resp;
          if (q[0].rd) begin
            for (int b = 0; b < 4; b++) begin
              bi = 12'(q[0].idx * 4 + b);
              ew[8*b +: 8] = mb[bi];
              m[8*b +: 8] = kv[bi] ? 8'hFF : 8'h00;
            end
          end
        end
        chk("HREADYOUT", g, {31'b0, hrdy[g]}, {31'b0, er}, 32'h1);
        chk("HRESP", g, {31'b0, hrsp[g]}, {31'b0, es}, 32'h1);
        chk("HRDATA", g, hrdata[g], ew, m);
      end
    end
  end

  function automatic void add(bit sel, logic [1:0] tr, bit wr,
                              logic [2:0] sz, logic [31:0] a,
                              logic [31:0] d);
    op_t o;
    o.sel = sel; o.tr = tr; o.wr = wr;
    o.sz = sz; o.a = a; o.d = d;
    ops.push_back(o);
  endfunction

  // pipelined master; called and returns at posedge+1
  task automatic run_ops(input int d);
    int i, dp, n, guard;
    bit r;
    i = 0; dp = -1; n = ops.size(); guard = 0;
    for (int k = 0; k < 64; k++) begin
      st[k] = 0; rsp0[k] = 0; rsp[k] = 0; rdv[k] = '0;
    end
    while ((i < n || dp >= 0) && guard < 2000) begin
      guard++;
      r = hrdy[d];
      if (dp >= 0) begin
        if (!r) begin
          st[dp]++;
          rsp0[dp] = hrsp[d];
        end else begin
          rdv[dp] = hrdata[d];
          rsp[dp] = hrsp[d];
        end
      end
      if (!r) begin
        hsel[d] = 1'($urandom);
        HTRANS  = 2'($urandom);
        HADDR   = $urandom;
        HWRITE  = 1'($urandom);
        HSIZE   = 3'($urandom);
      end else if (i < n) begin
        hsel[d] = ops[i].sel;
        HTRANS  = ops[i].tr;
        HADDR   = ops[i].a;
        HWRITE  = ops[i].wr;
        HSIZE   = ops[i].sz;
      end else begin
        hsel[d] = 1'b0;
        HTRANS  = 2'b00;
      end
      HBURST = 3'($urandom);
      @(posedge HCLK);
      #1;
      if (r) begin
        dp = -1;
        if (i < n) begin
          if (ops[i].sel && ops[i].tr[1]) begin
            dp = i;
            HWDATA = ops[i].d;
          end else begin
            HWDATA = $urandom;
          end
          i++;
        end
      end
    end
    checks++;
    if (guard >= 2000) begin
      fails++;
      $display("FAIL run_ops_timeout dut%0d got=%0d ops left, want 0", d, n - i);
    end
    hsel[d] = 1'b0;
    HTRANS  = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=no finish want=finish", $time);
    $fatal(1);
  end

  initial begin
    op_t o;
    #1 HRESET = 1'b1;
    #1 chk_en = 1'b1;
    #1;
    chk("rst_rdy", 1, {31'b0, hrdy[1]}, 32'h1, '1);
    chk("rst_resp", 1, {31'b0, hrsp[1]}, 32'h0, '1);
    chk("rst_rdata", 1, hrdata[1], 32'h0, '1);
    chk("rst_rdy", 0, {31'b0, hrdy[0]}, 32'h1, '1);
    @(posedge HCLK); @(posedge HCLK); #1 HRESET = 1'b0;

    // word write then read, one wait state each
    ops.delete();
    add(1, 2'd2, 1, 3'd2, 32'h10, 32'hDEADBEEF);
    add(1, 2'd2, 0, 3'd2, 32'h10, 32'h0);
    run_ops(1);
    chk("ws1_wr_stall", 1, st[0], 1, '1);
    chk("ws1_rd_stall", 1, st[1], 1, '1);
    chk("ws1_rd_data", 1, rdv[1], 32'hDEADBEEF, '1);
    chk("ws1_rd_resp", 1, {31'b0, rsp[1]}, 32'h0, '1);

    // sub-word writes
    ops.delete();
    add(1, 2'd2, 1, 3'd2, 32'h20, 32'h00000000);
    add(1, 2'd2, 1, 3'd0, 32'h21, 32'h0000AA00);
    add(1, 2'd3, 1, 3'd1, 32'h22, 32'h55660000);
    add(1, 2'd2, 0, 3'd2, 32'h20, 32'h0);
    run_ops(1);
    chk("lanes_rd", 1, rdv[3], 32'h5566AA00, '1);

    // errors, then an OKAY read of old data
    ops.delete();
    add(1, 2'd2, 1, 3'd2, 32'h0, 32'hCAFEF00D);
    add(1, 2'd2, 0, 3'd2, 32'h2, 32'h0);
    add(1, 2'd2, 0, 3'd2, 32'h1000, 32'h0);
    add(1, 2'd2, 0, 3'd2, 32'h0, 32'h0);
    run_ops(1);
    chk("mis_stall", 1, st[1], 1, '1);
    chk("mis_resp1", 1, {31'b0, rsp0[1]}, 32'h1, '1);
    chk("mis_resp2", 1, {31'b0, rsp[1]}, 32'h1, '1);
    chk("mis_rdata", 1, rdv[1], 32'h0, '1);
    chk("oor_stall", 1, st[2], 1, '1);
    chk("oor_resp1", 1, {31'b0, rsp0[2]}, 32'h1, '1);
    chk("oor_resp2", 1, {31'b0, rsp[2]}, 32'h1, '1);
    chk("after_err_rd", 1, rdv[3], 32'hCAFEF00D, '1);
    chk("after_err_resp", 1, {31'b0, rsp[3]}, 32'h0, '1);

    // zero wait states, back-to-back
    ops.delete();
    add(1, 2'd2, 1, 3'd2, 32'h40, 32'hA5A5F00F);
    add(1, 2'd2, 0, 3'd2, 32'h40, 32'h0);
    add(1, 2'd2, 1, 3'd2, 32'h44, 32'h12345678);
    add(1, 2'd2, 0, 3'd2, 32'h44, 32'h0);
    add(1, 2'd2, 0, 3'd2, 32'h40, 32'h0);
    run_ops(0);
    chk("ws0_stalls", 0, st[0] + st[1] + st[2], 0, '1);
    chk("ws0_raw", 0, rdv[1], 32'hA5A5F00F, '1);
    chk("ws0_wr2", 0, rdv[3], 32'h12345678, '1);
    chk("ws0_wr1", 0, rdv[4], 32'hA5A5F00F, '1);

    // reset during the wait state of a write
    ops.delete();
    add(1, 2'd2, 1, 3'd2, 32'h80, 32'h11111111);
    run_ops(1);
    hsel[1] = 1'b1; HTRANS = 2'd2; HWRITE = 1'b1;
    HSIZE = 3'd2; HADDR = 32'h80;
    @(posedge HCLK); #1;
    hsel[1] = 1'b0; HTRANS = 2'd0; HWDATA = 32'h22222222;
    chk("pre_rst_wait", 1, {31'b0, hrdy[1]}, 32'h0, '1);
    #2 HRESET = 1'b1;
    #1;
    chk("async_rdy", 1, {31'b0, hrdy[1]}, 32'h1, '1);
    chk("async_resp", 1, {31'b0, hrsp[1]}, 32'h0, '1);
    chk("async_rdata", 1, hrdata[1], 32'h0, '1);
    @(posedge HCLK); #1 HRESET = 1'b0;
    ops.delete();
    add(1, 2'd2, 0, 3'd2, 32'h80, 32'h0);
    run_ops(1);
    chk("post_rst_stall", 1, st[0], 1, '1);
    chk("post_rst_rd", 1, rdv[0], 32'h11111111, '1);

    // idle, busy and deselected cycles must not touch memory
    ops.delete();
    add(0, 2'd2, 1, 3'd2, 32'h10, 32'h0BADBAD0);
    add(1, 2'd0, 1, 3'd2, 32'h10, 32'h0BADBAD1);
    add(1, 2'd1, 1, 3'd2, 32'h10, 32'h0BADBAD2);
    add(1, 2'd2, 0, 3'd2, 32'h10, 32'h0);
    add(0, 2'd3, 1, 3'd0, 32'h11, 32'h0BADBAD3);
    add(1, 2'd1, 1, 3'd0, 32'h12, 32'h0BADBAD4);
    add(1, 2'd2, 0, 3'd0, 32'h13, 32'h0);
    run_ops(1);
    chk("nosel_rd", 1, rdv[3], 32'hDEADBEEF, '1);
    chk("nosel_byte_rd", 1, rdv[6], 32'hDEADBEEF, '1);

    // randomized traffic on both slaves
    for (int d = 1; d >= 0; d--) begin
      ops.delete();
      for (int k = 0; k < 60; k++) begin
        o.sel = ($urandom_range(0, 7) != 0);
        o.tr = ($urandom_range(0, 4) == 0) ? 2'($urandom)
             : (2'b10 | 2'($urandom_range(0, 1)));
        o.wr = 1'($urandom);
        o.sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7))
             : 3'($urandom_range(0, 2));
        o.a = 32'($urandom_range(0, 127));
        if ($urandom_range(0, 3) != 0 && o.sz <= 3'd2)
          o.a = o.a & ~((32'd1 << o.sz) - 32'd1);
        if ($urandom_range(0, 9) == 0)
          o.a = $urandom | 32'h1000;
        o.d = $urandom;
        ops.push_back(o);
      end
      run_ops(d);
    end

    repeat (3) @(posedge HCLK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
